control_sequencer: RTL and testbench

Fetch/execute control unit for the 4-bit processor. It sits directly downstream of the carry/zero flags register and consumes its C and Z outputs to resolve conditional jumps. It also latches the 8-bit program byte, runs the two-phase fetch/execute state machine, and drives every datapath strobe: PC, accumulator, flags enable, ALU select, bus source, RAM and output-port writes.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/instr_decoder.sv | 74 +++++++
 rtl/control_sequencer.sv | 103 ++++++++++
 tb/tb_control_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit processor: opcodes, ALU/bus selects,
// sequencer state encoding and the EXECUTE-cycle strobe bundle.
package cpu_pkg;

  localparam int unsigned OPW   = 4;
  localparam int unsigned DW    = 4;
  localparam int unsigned ALU_W = 2;
  localparam int unsigned BUS_W = 2;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  localparam logic [ALU_W-1:0] ALU_PASS = 2'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 2'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 2'd2;
  localparam logic [ALU_W-1:0] ALU_NAND = 2'd3;

  localparam logic [BUS_W-1:0] BUS_NONE    = 2'd0;
  localparam logic [BUS_W-1:0] BUS_OPERAND = 2'd1;
  localparam logic [BUS_W-1:0] BUS_RAM     = 2'd2;
  localparam logic [BUS_W-1:0] BUS_IN      = 2'd3;

  typedef enum logic {
    ST_FETCH   = 1'b0,
    ST_EXECUTE = 1'b1
  } state_t;

  typedef struct packed {
    logic             pc_load;
    logic             acc_en;
    logic             flags_en;
    logic             ram_we;
    logic             out_we;
    logic [ALU_W-1:0] alu_sel;
    logic [BUS_W-1:0] bus_sel;
  } exec_ctl_t;

  localparam exec_ctl_t EXEC_IDLE = '{
    pc_load:  1'b0,
    acc_en:   1'b0,
    flags_en: 1'b0,
    ram_we:   1'b0,
    out_we:   1'b0,
    alu_sel:  ALU_PASS,
    bus_sel:  BUS_NONE
  };

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode into the EXECUTE-cycle strobe bundle;
// conditional jumps resolve against the live carry/zero flags.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic           c_flag,
  input  logic           z_flag,
  output exec_ctl_t      ctl
);

  always_comb begin
    ctl = EXEC_IDLE;
    case (opcode)
      OPW'(OP_JC):    ctl.pc_load = c_flag;
      OPW'(OP_JNC):   ctl.pc_load = ~c_flag;
      OPW'(OP_CMPI): begin
        ctl.alu_sel  = ALU_SUB;
        ctl.bus_sel  = BUS_OPERAND;
        ctl.flags_en = 1'b1;
      end
      OPW'(OP_CMPM): begin
        ctl.alu_sel  = ALU_SUB;
        ctl.bus_sel  = BUS_RAM;
        ctl.flags_en = 1'b1;
      end
      OPW'(OP_LIT): begin
        ctl.bus_sel = BUS_OPERAND;
        ctl.acc_en  = 1'b1;
      end
      OPW'(OP_IN): begin
        ctl.bus_sel = BUS_IN;
        ctl.acc_en  = 1'b1;
      end
      OPW'(OP_LD): begin
        ctl.bus_sel = BUS_RAM;
        ctl.acc_en  = 1'b1;
      end
      OPW'(OP_ST):    ctl.ram_we  = 1'b1;
      OPW'(OP_JZ):    ctl.pc_load = z_flag;
      OPW'(OP_JNZ):   ctl.pc_load = ~z_flag;
      OPW'(OP_ADDI): begin
        ctl.alu_sel  = ALU_ADD;
        ctl.bus_sel  = BUS_OPERAND;
        ctl.acc_en   = 1'b1;
        ctl.flags_en = 1'b1;
      end
      OPW'(OP_ADDM): begin
        ctl.alu_sel  = ALU_ADD;
        ctl.bus_sel  = BUS_RAM;
        ctl.acc_en   = 1'b1;
        ctl.flags_en = 1'b1;
      end
      OPW'(OP_JMP):   ctl.pc_load = 1'b1;
      OPW'(OP_OUT):   ctl.out_we  = 1'b1;
      OPW'(OP_NANDI): begin
        ctl.alu_sel  = ALU_NAND;
        ctl.bus_sel  = BUS_OPERAND;
        ctl.acc_en   = 1'b1;
        ctl.flags_en = 1'b1;
      end
      OPW'(OP_NANDM): begin
        ctl.alu_sel  = ALU_NAND;
        ctl.bus_sel  = BUS_RAM;
        ctl.acc_en   = 1'b1;
        ctl.flags_en = 1'b1;
      end
      default: ctl = EXEC_IDLE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control unit: latches the program byte, runs the two-phase
// FSM and drives all datapath strobes (combinational, gated by phase and reset).
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 4,
  parameter int unsigned DW  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [OPW+DW-1:0]  prog_byte,
  input  logic               c_flag,
  input  logic               z_flag,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               acc_en,
  output logic               flags_en,
  output logic [ALU_W-1:0]   alu_sel,
  output logic [BUS_W-1:0]   bus_sel,
  output logic               ram_we,
  output logic               out_we,
  output logic [DW-1:0]      operand,
  output logic               phase
);

  localparam int unsigned IRW = OPW + DW;

  state_t         state;
  state_t         state_nxt;
  logic [IRW-1:0] ir;
  logic           fetch_go;
  exec_ctl_t      dec_ctl;

  assign fetch_go = (state == ST_FETCH) && (run || step);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:   if (run || step) state_nxt = ST_EXECUTE;
      ST_EXECUTE: state_nxt = ST_FETCH;
      default:    state_nxt = ST_FETCH;
    endcase
  end

  // Instruction register: captured on the FETCH advance edge only
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ir <= '0;
    else if (fetch_go) ir <= prog_byte;
  end

  instr_decoder #(
    .OPW (OPW)
  ) u_decoder (
    .opcode (ir[IRW-1:DW]),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .ctl    (dec_ctl)
  );

  // Reset overrides everything so an in-flight EXECUTE is aborted at once
  always_comb begin
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_en   = 1'b0;
    flags_en = 1'b0;
    ram_we   = 1'b0;
    out_we   = 1'b0;
    alu_sel  = ALU_PASS;
    bus_sel  = BUS_NONE;
    operand  = '0;
    phase    = 1'b0;
    if (!reset) begin
      operand = ir[DW-1:0];
      case (state)
        ST_FETCH: begin
          ir_load = fetch_go;
          pc_inc  = fetch_go;
        end
        ST_EXECUTE: begin
          phase    = 1'b1;
          pc_load  = dec_ctl.pc_load;
          acc_en   = dec_ctl.acc_en;
          flags_en = dec_ctl.flags_en;
          ram_we   = dec_ctl.ram_we;
          out_we   = dec_ctl.out_we;
          alu_sel  = dec_ctl.alu_sel;
          bus_sel  = dec_ctl.bus_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table plus hand sequences
// for single-step and reset-during-EXECUTE.
module tb_control_sequencer;

  typedef struct packed {
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_en;
    logic       flags_en;
    logic       ram_we;
    logic       out_we;
    logic [1:0] alu_sel;
    logic [1:0] bus_sel;
    logic [3:0] operand;
    logic       phase;
  } obs_t;

  typedef struct {
    string      name;
    logic       run;
    logic       step;
    logic [7:0] pb;
    logic       c;
    logic       z;
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       step;
  logic [7:0] prog_byte;
  logic       c_flag;
  logic       z_flag;
  logic       ir_load, pc_inc, pc_load, acc_en, flags_en, ram_we, out_we, phase;
  logic [1:0] alu_sel, bus_sel;
  logic [3:0] operand;

  int total = 0;
  int bad   = 0;

  vec_t       vecs[$];
  logic [3:0] cur_opnd;

  control_sequencer #(.OPW(4), .DW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .prog_byte (prog_byte),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .acc_en    (acc_en),
    .flags_en  (flags_en),
    .alu_sel   (alu_sel),
    .bus_sel   (bus_sel),
    .ram_we    (ram_we),
    .out_we    (out_we),
    .operand   (operand),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic obs_t sample();
    obs_t o;
    o = {ir_load, pc_inc, pc_load, acc_en, flags_en, ram_we, out_we,
         alu_sel, bus_sel, operand, phase};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t got;
    got = sample();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (ir_load pc_inc pc_load acc flg ram out alu bus opnd phase)",
               name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic add_hold(input string name);
    vec_t v;
    v.name = name; v.run = 1'b0; v.step = 1'b0; v.pb = 8'h4A;
    v.c = 1'b0; v.z = 1'b0;
    v.exp = '0;
    v.exp.operand = cur_opnd;
    vecs.push_back(v);
  endtask

  // FETCH cycle: operand still shows the previous IR
  task automatic add_fetch(input string name, input logic [7:0] pb);
    vec_t v;
    v.name = name; v.run = 1'b1; v.step = 1'b0; v.pb = pb;
    v.c = 1'b0; v.z = 1'b0;
    v.exp = '0;
    v.exp.ir_load = 1'b1;
    v.exp.pc_inc  = 1'b1;
    v.exp.operand = cur_opnd;
    vecs.push_back(v);
    cur_opnd = pb[3:0];
  endtask

  // EXECUTE cycle: prog_byte is junk and run is free to change
  task automatic add_exec(input string name, input logic r, input logic c, input logic z,
                          input logic pl, input logic acc, input logic flg,
                          input logic ram, input logic outw,
                          input logic [1:0] alu, input logic [1:0] bus);
    vec_t v;
    v.name = name; v.run = r; v.step = 1'b0; v.pb = 8'hFF;
    v.c = c; v.z = z;
    v.exp = '0;
    v.exp.pc_load  = pl;
    v.exp.acc_en   = acc;
    v.exp.flags_en = flg;
    v.exp.ram_we   = ram;
    v.exp.out_we   = outw;
    v.exp.alu_sel  = alu;
    v.exp.bus_sel  = bus;
    v.exp.operand  = cur_opnd;
    v.exp.phase    = 1'b1;
    vecs.push_back(v);
  endtask

  int   ram_cnt, out_cnt, irl_cnt, idle_cnt;
  obs_t e;

  task automatic step_pulse(input logic [7:0] pb);
    ram_cnt = 0; out_cnt = 0; irl_cnt = 0; idle_cnt = 0;
    @(negedge clk);
    run = 1'b0; step = 1'b1; prog_byte = pb;
    #2;
    irl_cnt += int'(ir_load);
    @(negedge clk);
    step = 1'b0; prog_byte = 8'h00;
    for (int k = 0; k < 6; k++) begin
      #2;
      ram_cnt += int'(ram_we);
      out_cnt += int'(out_we);
      irl_cnt += int'(ir_load);
      if (k >= 1)
        idle_cnt += int'(ir_load | pc_inc | pc_load | acc_en | flags_en | ram_we | out_we);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; step = 1'b0; prog_byte = 8'h4A;
    c_flag = 1'b1; z_flag = 1'b1;
    cur_opnd = 4'h0;

    // ALU codes: PASS=0 ADD=1 SUB=2 NAND=3; bus: NONE=0 OPERAND=1 RAM=2 IN=3
    add_hold("hold0"); add_hold("hold1"); add_hold("hold2");
    add_fetch("lit_fetch", 8'h4A);
    add_exec ("lit_exec",  1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd1);
    add_fetch("addi_fetch", 8'hA3);
    add_exec ("addi_exec", 1, 0, 0, 0, 1, 1, 0, 0, 2'd1, 2'd1);
    add_fetch("jc1_fetch", 8'h05);
    add_exec ("jc_c1",     1, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jc0_fetch", 8'h05);
    add_exec ("jc_c0",     0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jz_fetch_a", 8'h80);
    add_exec ("jz_z0c0",   1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jz_fetch_b", 8'h80);
    add_exec ("jz_z1c1",   1, 1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jnz_fetch_a", 8'h91);
    add_exec ("jnz_z0c1",  1, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jnz_fetch_b", 8'h91);
    add_exec ("jnz_z1c0",  1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jnc_fetch_a", 8'h12);
    add_exec ("jnc_c0z1",  1, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jnc_fetch_b", 8'h12);
    add_exec ("jnc_c1z0",  1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jmp_fetch_a", 8'hC7);
    add_exec ("jmp_c0z0",  1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("jmp_fetch_b", 8'hC7);
    add_exec ("jmp_c1z1",  1, 1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_fetch("cmpi_fetch", 8'h29);
    add_exec ("cmpi_exec", 1, 1, 1, 0, 0, 1, 0, 0, 2'd2, 2'd1);
    add_fetch("cmpm_fetch", 8'h3E);
    add_exec ("cmpm_exec", 1, 0, 0, 0, 0, 1, 0, 0, 2'd2, 2'd2);
    add_fetch("in_fetch", 8'h51);
    add_exec ("in_exec",   1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd3);
    add_fetch("ld_fetch", 8'h6C);
    add_exec ("ld_exec",   1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd2);
    add_fetch("st_fetch", 8'h74);
    add_exec ("st_exec",   1, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0);
    add_fetch("addm_fetch", 8'hB8);
    add_exec ("addm_exec", 1, 0, 0, 0, 1, 1, 0, 0, 2'd1, 2'd2);
    add_fetch("out_fetch", 8'hD6);
    add_exec ("out_exec",  1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
    add_fetch("nandi_fetch", 8'hE5);
    add_exec ("nandi_exec", 1, 0, 0, 0, 1, 1, 0, 0, 2'd3, 2'd1);
    add_fetch("nandm_fetch", 8'hFB);
    add_exec ("nandm_exec", 0, 0, 0, 0, 1, 1, 0, 0, 2'd3, 2'd2);
    add_hold("hold_after");

    // Strobes forced idle while reset is asserted, even with run=1
    #2;
    check_obs("in_reset", obs_t'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; run = 1'b0;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      run = vecs[i].run; step = vecs[i].step; prog_byte = vecs[i].pb;
      c_flag = vecs[i].c; z_flag = vecs[i].z;
      #2;
      check_obs(vecs[i].name, vecs[i].exp);
    end

    // Single step: one pulse each for ST then OUT
    step_pulse(8'h73);
    check_int("step_st_ir_load", irl_cnt, 1);
    check_int("step_st_ram_we", ram_cnt, 1);
    check_int("step_st_out_we", out_cnt, 0);
    check_int("step_st_idle", idle_cnt, 0);
    step_pulse(8'hD5);
    check_int("step_out_ir_load", irl_cnt, 1);
    check_int("step_out_out_we", out_cnt, 1);
    check_int("step_out_ram_we", ram_cnt, 0);
    check_int("step_out_idle", idle_cnt, 0);

    // Reset during EXECUTE of ADDM B2
    @(negedge clk);
    run = 1'b1; prog_byte = 8'hB2; c_flag = 1'b0; z_flag = 1'b0;
    #2;
    e = '0; e.ir_load = 1'b1; e.pc_inc = 1'b1; e.operand = 4'h5;
    check_obs("addm_rst_fetch", e);
    @(negedge clk);
    run = 1'b0; prog_byte = 8'h00;
    #2;
    e = '0; e.acc_en = 1'b1; e.flags_en = 1'b1; e.alu_sel = 2'd1; e.bus_sel = 2'd2;
    e.operand = 4'h2; e.phase = 1'b1;
    check_obs("addm_exec_pre_rst", e);
    #1 reset = 1'b1;
    #1;
    check_obs("addm_rst_abort", obs_t'(0));
    @(negedge clk);
    reset = 1'b0;
    #2;
    check_obs("post_rst_idle", obs_t'(0));
    @(negedge clk);
    run = 1'b1; prog_byte = 8'h4A;
    #2;
    e = '0; e.ir_load = 1'b1; e.pc_inc = 1'b1; e.operand = 4'h0;
    check_obs("post_rst_fetch", e);
    @(negedge clk);
    run = 1'b0; prog_byte = 8'h00;
    #2;
    e = '0; e.acc_en = 1'b1; e.bus_sel = 2'd1; e.operand = 4'hA; e.phase = 1'b1;
    check_obs("post_rst_exec", e);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
